// File: rtl/imu_axil_pkg.sv
// Shared constants and helpers for the IMU AXI4-Lite register block.
// Register indices, response code and byte-lane merge live here.
package imu_axil_pkg;

    localparam int         REG_COUNT = 4;
    localparam logic [1:0] REG_IDX0  = 2'd0;
    localparam logic [1:0] REG_IDX1  = 2'd1;
    localparam logic [1:0] REG_IDX2  = 2'd2;
    localparam logic [1:0] REG_IDX3  = 2'd3;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/imu_axil_wbuf.sv
// Independent AW / W holding buffers and the commit / B-response handshake.
// A commit fires the cycle both buffers hold a beat; only one write is in flight.
module imu_axil_wbuf
    import imu_axil_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  aw_idx,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_valid,
    output logic        w_ready,
    output logic        b_valid,
    input  logic        b_ready,
    output logic        commit,
    output logic [1:0]  commit_idx,
    output logic [31:0] commit_data,
    output logic [3:0]  commit_strb
);

    logic        aw_full_q, aw_full_d;
    logic        w_full_q, w_full_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic        bvalid_q, bvalid_d;

    assign aw_ready    = en && !aw_full_q && !bvalid_q;
    assign w_ready     = en && !w_full_q && !bvalid_q;
    assign b_valid     = bvalid_q;
    assign commit      = aw_full_q && w_full_q;
    assign commit_idx  = idx_q;
    assign commit_data = data_q;
    assign commit_strb = strb_q;

    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        idx_d     = idx_q;
        data_d    = data_q;
        strb_d    = strb_q;
        bvalid_d  = bvalid_q;
        if (aw_valid && aw_ready) begin
            aw_full_d = 1'b1;
            idx_d     = aw_idx;
        end
        if (w_valid && w_ready) begin
            w_full_d = 1'b1;
            data_d   = w_data;
            strb_d   = w_strb;
        end
        // Readies are low while both are full, so a commit never meets a new beat.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else if (bvalid_q && b_ready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            idx_q     <= REG_IDX0;
            data_q    <= '0;
            strb_q    <= '0;
            bvalid_q  <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            bvalid_q  <= bvalid_d;
        end
    end

endmodule

// File: rtl/imu_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit control words to IMU user logic.
// Write buffering lives in imu_axil_wbuf; the read path is handled here.
module imu_axil_regs
    import imu_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [127:0]                    REGS_O,
    output logic [3:0]                      WR_PULSE_O
);

    logic            en_q, en_d;
    logic [3:0][31:0] regs_q, regs_d;
    logic [3:0]      wr_pulse_q, wr_pulse_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            commit;
    logic [1:0]      commit_idx;
    logic [31:0]     commit_data;
    logic [3:0]      commit_strb;
    logic [1:0]      ar_idx;
    logic [31:0]     rd_word;
    logic            ar_hs;
    logic            unused_in;

    assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    imu_axil_wbuf u_wbuf (
        .clk         (ACLK),
        .rst         (ARESET),
        .en          (en_q),
        .aw_idx      (S_AXI_AWADDR[3:2]),
        .aw_valid    (S_AXI_AWVALID),
        .aw_ready    (S_AXI_AWREADY),
        .w_data      (S_AXI_WDATA),
        .w_strb      (S_AXI_WSTRB),
        .w_valid     (S_AXI_WVALID),
        .w_ready     (S_AXI_WREADY),
        .b_valid     (S_AXI_BVALID),
        .b_ready     (S_AXI_BREADY),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb)
    );

    // en_q holds every READY low until the first edge after reset release.
    assign en_d          = 1'b1;
    assign ar_idx        = S_AXI_ARADDR[3:2];
    assign S_AXI_ARREADY = en_q && !rvalid_q;
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign REGS_O        = regs_q;
    assign WR_PULSE_O    = wr_pulse_q;

    always_comb begin
        rd_word = regs_q[0];
        unique case (ar_idx)
            REG_IDX0: rd_word = regs_q[0];
            REG_IDX1: rd_word = regs_q[1];
            REG_IDX2: rd_word = regs_q[2];
            REG_IDX3: rd_word = regs_q[3];
        endcase
    end

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;
        if (commit) begin
            regs_d[commit_idx] = apply_strb(regs_q[commit_idx],
                                            commit_data, commit_strb);
            wr_pulse_d[commit_idx] = 1'b1;
        end
        // rd_word comes from regs_q, so a same-edge write is not visible yet.
        if (ar_hs) begin
            rdata_d  = rd_word;
            rvalid_d = 1'b1;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            en_q       <= 1'b0;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            en_q       <= en_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_imu_axil_regs.sv
// Scoreboard bench for imu_axil_regs: tasks drive AXI-Lite traffic and queue
// expectations from a word-array model; negedge monitors pop and compare.
module tb_imu_axil_regs;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b0;
    logic [3:0]   AWADDR = '0;
    logic [2:0]   AWPROT = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b1;
    logic [3:0]   ARADDR = '0;
    logic [2:0]   ARPROT = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b1;
    logic [127:0] REGS_O;
    logic [3:0]   WR_PULSE_O;

    int checks = 0;
    int errors = 0;

    logic [31:0]  model [4];
    logic [127:0] bexp_q [$];
    logic [31:0]  rexp_q [$];
    logic [3:0]   pexp_q [$];

    always #5 ACLK = ~ACLK;

    imu_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (AWADDR),
        .S_AXI_AWPROT  (AWPROT),
        .S_AXI_AWVALID (AWVALID),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (WDATA),
        .S_AXI_WSTRB   (WSTRB),
        .S_AXI_WVALID  (WVALID),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (BREADY),
        .S_AXI_ARADDR  (ARADDR),
        .S_AXI_ARPROT  (ARPROT),
        .S_AXI_ARVALID (ARVALID),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (RREADY),
        .REGS_O        (REGS_O),
        .WR_PULSE_O    (WR_PULSE_O)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic logic [127:0] snap();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    always @(negedge ACLK) begin
        if (!ARESET && BVALID && BREADY) begin
            if (bexp_q.size() == 0) begin
                tmo("unexpected_bvalid");
            end else begin
                logic [127:0] r;
                r = bexp_q.pop_front();
                chk("bresp", {126'd0, BRESP}, 128'd0);
                chk("regs_o_after_write", REGS_O, r);
            end
        end
    end

    always @(negedge ACLK) begin
        if (!ARESET && RVALID && RREADY) begin
            if (rexp_q.size() == 0) begin
                tmo("unexpected_rvalid");
            end else begin
                logic [31:0] d;
                d = rexp_q.pop_front();
                chk("rdata", {96'd0, RDATA}, {96'd0, d});
                chk("rresp", {126'd0, RRESP}, 128'd0);
            end
        end
    end

    always @(negedge ACLK) begin
        if (!ARESET && WR_PULSE_O != 4'd0) begin
            if (pexp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_pulse unexpected actual=%b", WR_PULSE_O);
            end else begin
                logic [3:0] p;
                p = pexp_q.pop_front();
                chk("wr_pulse", {124'd0, WR_PULSE_O}, {124'd0, p});
            end
        end
    end

    // lead > 0: W goes out lead cycles before AW; lead < 0: AW first.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead);
        bit aw_done, w_done, aw_hs, w_hs;
        int t, dly_aw, dly_w;
        logic [1:0] idx;
        aw_done = 0;
        w_done  = 0;
        dly_aw  = lead > 0 ? lead : 0;
        dly_w   = lead < 0 ? -lead : 0;
        for (t = 0; t < 100 && !(aw_done && w_done); t++) begin
            if (!aw_done && t >= dly_aw) begin
                AWADDR  = addr;
                AWVALID = 1'b1;
            end
            if (!w_done && t >= dly_w) begin
                WDATA  = data;
                WSTRB  = strb;
                WVALID = 1'b1;
            end
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge ACLK);
            #1;
            if (aw_hs) begin
                aw_done = 1;
                AWVALID = 1'b0;
            end
            if (w_hs) begin
                w_done = 1;
                WVALID = 1'b0;
            end
        end
        if (!(aw_done && w_done)) begin
            tmo("write_accept");
            AWVALID = 1'b0;
            WVALID  = 1'b0;
            return;
        end
        // The write takes effect on the edge after both halves are accepted.
        @(posedge ACLK);
        #2;
        idx = addr[3:2];
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) model[idx][8*i +: 8] = data[8*i +: 8];
        end
        pexp_q.push_back(4'b0001 << idx);
        bexp_q.push_back(snap());
        for (t = 0; t < 200; t++) begin
            @(negedge ACLK);
            if (BVALID && BREADY) break;
        end
        if (t == 200) tmo("b_wait");
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, input int rdelay);
        int t;
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = (rdelay == 0);
        for (t = 0; t < 100; t++) begin
            @(negedge ACLK);
            if (ARREADY) break;
        end
        if (t == 100) begin
            tmo("ar_accept");
            ARVALID = 1'b0;
            RREADY  = 1'b1;
            return;
        end
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
        rexp_q.push_back(model[addr[3:2]]);
        repeat (rdelay) @(posedge ACLK);
        if (rdelay != 0) #1;
        RREADY = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge ACLK);
            if (RVALID && RREADY) break;
        end
        if (t == 100) tmo("r_wait");
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, {127'd0, AWREADY}, 128'd0);
        chk({tag, "_wready"}, {127'd0, WREADY}, 128'd0);
        chk({tag, "_bvalid"}, {127'd0, BVALID}, 128'd0);
        chk({tag, "_arready"}, {127'd0, ARREADY}, 128'd0);
        chk({tag, "_rvalid"}, {127'd0, RVALID}, 128'd0);
        chk({tag, "_rdata"}, {96'd0, RDATA}, 128'd0);
        chk({tag, "_regs_o"}, REGS_O, 128'd0);
        chk({tag, "_wr_pulse"}, {124'd0, WR_PULSE_O}, 128'd0);
    endtask

    task automatic chk_readies_up(input string tag);
        chk({tag, "_awready_up"}, {127'd0, AWREADY}, 128'd1);
        chk({tag, "_wready_up"}, {127'd0, WREADY}, 128'd1);
        chk({tag, "_arready_up"}, {127'd0, ARREADY}, 128'd1);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 4; i++) model[i] = '0;

        #1 ARESET = 1'b1;
        #2 chk_all_zero("reset");
        repeat (2) @(posedge ACLK);
        #3 ARESET = 1'b0;
        #1 chk("ready_low_before_edge", {127'd0, AWREADY}, 128'd0);
        @(posedge ACLK);
        #1 chk_readies_up("post_reset");

        axi_write(4'h0, 32'h1, 4'hF, 0);
        axi_write(4'h4, 32'h2, 4'hF, 0);
        axi_write(4'h8, 32'h3, 4'hF, 0);
        axi_write(4'hC, 32'h4, 4'hF, 0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
        chk("regs_o_basic", REGS_O,
            128'h00000004_00000003_00000002_00000001);

        axi_write(4'h8, 32'hAABBCCDD, 4'hF, 3);
        chk("reg2_w_first", {96'd0, REGS_O[95:64]}, {96'd0, 32'hAABBCCDD});

        axi_write(4'h5, 32'h11223344, 4'hF, -2);
        axi_write(4'h4, 32'hFFFFFFFF, 4'b0101, 0);
        chk("reg1_strobe", {96'd0, REGS_O[63:32]}, {96'd0, 32'h11FF33FF});
        axi_read(4'h6, 2);
        axi_write(4'h4, 32'h0BADF00D, 4'h0, 1);
        chk("reg1_zero_strb", {96'd0, REGS_O[63:32]}, {96'd0, 32'h11FF33FF});

        BREADY = 1'b0;
        fork
            begin
                axi_write(4'h4, 32'hCAFE0001, 4'hF, 0);
                axi_write(4'hC, 32'hBEEF0002, 4'hF, -1);
            end
            begin
                for (t = 0; t < 100; t++) begin
                    @(negedge ACLK);
                    if (BVALID) break;
                end
                if (t == 100) tmo("bvalid_rise");
                repeat (10) begin
                    @(negedge ACLK);
                    chk("hold_bvalid", {127'd0, BVALID}, 128'd1);
                    chk("hold_awready", {127'd0, AWREADY}, 128'd0);
                    chk("hold_wready", {127'd0, WREADY}, 128'd0);
                end
                @(posedge ACLK);
                #1 BREADY = 1'b1;
            end
        join

        axi_write(4'h0, 32'h12345678, 4'hF, 0);
        fork
            axi_write(4'h0, 32'h00000055, 4'hF, 0);
            begin
                @(posedge ACLK);
                #1 axi_read(4'h0, 0);
            end
        join
        axi_read(4'h0, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                axi_write(4'($urandom_range(0, 15)), $urandom,
                          4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 6)) - 3);
            else
                axi_read(4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)));
        end

        AWADDR  = 4'hC;
        AWVALID = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge ACLK);
            if (AWREADY) break;
        end
        if (t == 100) tmo("rst_aw_accept");
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
        RREADY  = 1'b0;
        ARADDR  = 4'h4;
        ARVALID = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge ACLK);
            if (ARREADY) break;
        end
        if (t == 100) tmo("rst_ar_accept");
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
        chk("rvalid_before_reset", {127'd0, RVALID}, 128'd1);
        #2 ARESET = 1'b1;
        #1 chk_all_zero("mid_reset");
        for (int i = 0; i < 4; i++) model[i] = '0;
        bexp_q.delete();
        rexp_q.delete();
        pexp_q.delete();
        RREADY = 1'b1;
        WDATA  = 32'hDEADBEEF;
        WSTRB  = 4'hF;
        @(posedge ACLK);
        #3 ARESET = 1'b0;
        @(posedge ACLK);
        #1 chk_readies_up("post_reset2");
        repeat (5) @(posedge ACLK);
        #1;
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
        axi_write(4'h4, 32'h600DCAFE, 4'hF, 2);
        axi_read(4'h4, 1);
        axi_read(4'hC, 0);

        repeat (4) @(posedge ACLK);
        #1;
        chk("bexp_drained", 128'(bexp_q.size()), 128'd0);
        chk("rexp_drained", 128'(rexp_q.size()), 128'd0);
        chk("pexp_drained", 128'(pexp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1, "global timeout");
    end

endmodule
